// File: rtl/pps_input_conditioner_if.sv
// rtl/pps_input_conditioner_if.sv - status/output bundle of the PPS input conditioner
interface pps_input_conditioner_if;
    logic        pps_clean;
    logic        pps_strobe;
    logic [31:0] width_cycles;
    logic        width_error;
    logic [31:0] period_cycles;
    logic        period_valid;
    logic        stuck_high;
    logic [15:0] glitch_count;
    logic [15:0] reject_count;

    modport master (
        output pps_clean, pps_strobe, width_cycles, width_error, period_cycles,
               period_valid, stuck_high, glitch_count, reject_count
    );

    modport slave (
        input  pps_clean, pps_strobe, width_cycles, width_error, period_cycles,
               period_valid, stuck_high, glitch_count, reject_count
    );
endinterface

// File: rtl/pps_input_conditioner.sv
// rtl/pps_input_conditioner.sv - synchronise, deglitch, qualify and regenerate an external PPS
module pps_input_conditioner #(
    parameter int SYNC_STAGES    = 2,
    parameter int INVERT         = 0,
    parameter int GLITCH_CYCLES  = 4,
    parameter int MIN_WIDTH      = 100,
    parameter int MAX_WIDTH      = 50_000_000,
    parameter int HOLDOFF_CYCLES = 90_000_000,
    parameter int OUT_WIDTH      = 10_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pps_raw,
    pps_input_conditioner_if.master   st
);
    localparam logic        INV  = (INVERT != 0);
    localparam logic [31:0] GC   = 32'(GLITCH_CYCLES);
    localparam logic [31:0] MINW = 32'(MIN_WIDTH);
    localparam logic [31:0] MAXW = 32'(MAX_WIDTH);
    localparam logic [31:0] HOLD = 32'(HOLDOFF_CYCLES);
    localparam logic [31:0] OUTW = 32'(OUT_WIDTH);

    typedef enum logic [2:0] {WAIT_LOW, ARMED, QUAL, HIGH, STUCK, HOLDOFF} state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES-1:0] sync_valid;
    logic                   s, s_prev, s_ok, rise;

    state_t      state, state_next;
    logic [31:0] qcnt, qcnt_next, wcnt, wcnt_next, pcnt, ocnt, width_val;
    logic        have_prev;
    logic        accept, glitch_inc, reject_inc, width_load, width_err_set, stuck_set, stuck_clr;

    assign s    = sync[SYNC_STAGES-1];
    assign s_ok = sync_valid[SYNC_STAGES-1];
    assign rise = s & ~s_prev;

    // sync_valid marks when s reflects the pin rather than reset zeros, so a pin
    // already high at reset release is never mistaken for a low level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync       <= '0;
            sync_valid <= '0;
            s_prev     <= 1'b0;
        end else begin
            sync       <= {sync[SYNC_STAGES-2:0], pps_raw ^ INV};
            sync_valid <= {sync_valid[SYNC_STAGES-2:0], 1'b1};
            s_prev     <= s;
        end
    end

    always_comb begin
        state_next    = state;
        qcnt_next     = qcnt;
        wcnt_next     = wcnt;
        accept        = 1'b0;
        glitch_inc    = 1'b0;
        reject_inc    = 1'b0;
        width_load    = 1'b0;
        width_val     = wcnt;
        width_err_set = 1'b0;
        stuck_set     = 1'b0;
        stuck_clr     = 1'b0;
        case (state)
            WAIT_LOW: if (s_ok && !s) state_next = ARMED;
            ARMED: begin
                if (s) begin
                    if (GC == 32'd1) begin
                        accept     = 1'b1;
                        wcnt_next  = GC;
                        state_next = HIGH;
                    end else begin
                        qcnt_next  = 32'd1;
                        state_next = QUAL;
                    end
                end
            end
            QUAL: begin
                if (!s) begin
                    glitch_inc = 1'b1;
                    state_next = ARMED;
                end else if (qcnt == GC - 32'd1) begin
                    accept     = 1'b1;
                    wcnt_next  = GC;
                    state_next = HIGH;
                end else begin
                    qcnt_next = qcnt + 32'd1;
                end
            end
            HIGH: begin
                if (s) begin
                    if (wcnt + 32'd1 >= MAXW) begin
                        wcnt_next     = MAXW;
                        width_load    = 1'b1;
                        width_val     = MAXW;
                        width_err_set = 1'b1;
                        stuck_set     = 1'b1;
                        state_next    = STUCK;
                    end else begin
                        wcnt_next = wcnt + 32'd1;
                    end
                end else begin
                    width_load    = 1'b1;
                    width_err_set = (wcnt < MINW);
                    state_next    = HOLDOFF;
                end
            end
            STUCK: begin
                if (!s) begin
                    stuck_clr  = 1'b1;
                    state_next = HOLDOFF;
                end
            end
            HOLDOFF: begin
                reject_inc = rise;
                if (pcnt >= HOLD) state_next = s ? WAIT_LOW : ARMED;
            end
            default: state_next = WAIT_LOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= WAIT_LOW;
            qcnt             <= '0;
            wcnt             <= '0;
            pcnt             <= '0;
            ocnt             <= '0;
            have_prev        <= 1'b0;
            st.pps_clean     <= 1'b0;
            st.pps_strobe    <= 1'b0;
            st.width_cycles  <= '0;
            st.width_error   <= 1'b0;
            st.period_cycles <= '0;
            st.period_valid  <= 1'b0;
            st.stuck_high    <= 1'b0;
            st.glitch_count  <= '0;
            st.reject_count  <= '0;
        end else begin
            state          <= state_next;
            qcnt           <= qcnt_next;
            wcnt           <= wcnt_next;
            st.pps_strobe  <= accept;
            st.width_error <= width_err_set;
            if (width_load) st.width_cycles <= width_val;
            if (stuck_set)      st.stuck_high <= 1'b1;
            else if (stuck_clr) st.stuck_high <= 1'b0;
            if (glitch_inc && st.glitch_count != 16'hFFFF) st.glitch_count <= st.glitch_count + 16'd1;
            if (reject_inc && st.reject_count != 16'hFFFF) st.reject_count <= st.reject_count + 16'd1;

            // pcnt counts from the accept cycle, so it equals the strobe spacing at the next accept.
            if (accept) begin
                pcnt      <= 32'd1;
                have_prev <= 1'b1;
                if (have_prev) begin
                    st.period_cycles <= pcnt;
                    st.period_valid  <= 1'b1;
                end
            end else if (pcnt == 32'hFFFF_FFFF) begin
                st.period_valid <= 1'b0;
                have_prev       <= 1'b0;
            end else begin
                pcnt <= pcnt + 32'd1;
            end

            if (accept) begin
                st.pps_clean <= 1'b1;
                ocnt         <= 32'd1;
            end else if (st.pps_clean) begin
                if (ocnt >= OUTW) st.pps_clean <= 1'b0;
                else              ocnt <= ocnt + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_pps_input_conditioner.sv
// tb/tb_pps_input_conditioner.sv - directed scoreboard bench for pps_input_conditioner
module tb_pps_input_conditioner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw = 1'b0;
    logic raw_n = 1'b1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int sb[$];
    int sb_n[$];
    int werr_count = 0;
    int clean_run = 0;
    int clean_run_n = 0;

    always #5 clk = ~clk;

    pps_input_conditioner_if bus();
    pps_input_conditioner_if bus_n();

    pps_input_conditioner #(
        .SYNC_STAGES(2), .INVERT(0), .GLITCH_CYCLES(4), .MIN_WIDTH(10),
        .MAX_WIDTH(1000), .HOLDOFF_CYCLES(5000), .OUT_WIDTH(50)
    ) dut (
        .clk(clk), .rst(rst), .pps_raw(raw), .st(bus)
    );

    pps_input_conditioner #(
        .SYNC_STAGES(2), .INVERT(1), .GLITCH_CYCLES(4), .MIN_WIDTH(10),
        .MAX_WIDTH(1000), .HOLDOFF_CYCLES(5000), .OUT_WIDTH(50)
    ) dut_n (
        .clk(clk), .rst(rst), .pps_raw(raw_n), .st(bus_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int len, input bit expect_strobe);
        if (expect_strobe) sb.push_back(cyc + 6);
        raw = 1'b1;
        tick(len);
        raw = 1'b0;
    endtask

    task automatic pulse_n(input int len);
        sb_n.push_back(cyc + 6);
        raw_n = 1'b0;
        tick(len);
        raw_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_clean"},  32'(bus.pps_clean), 32'd0);
        check({tag, "_strobe"}, 32'(bus.pps_strobe), 32'd0);
        check({tag, "_width"},  bus.width_cycles, 32'd0);
        check({tag, "_werr"},   32'(bus.width_error), 32'd0);
        check({tag, "_period"}, bus.period_cycles, 32'd0);
        check({tag, "_pvalid"}, 32'(bus.period_valid), 32'd0);
        check({tag, "_stuck"},  32'(bus.stuck_high), 32'd0);
        check({tag, "_glitch"}, 32'(bus.glitch_count), 32'd0);
        check({tag, "_reject"}, 32'(bus.reject_count), 32'd0);
    endtask

    always @(posedge clk) cyc++;

    // Output monitor: strobes are matched against the scoreboard, clean pulses are width-checked.
    always @(negedge clk) begin
        if (bus.pps_strobe) begin
            check("strobe_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) check("strobe_cycle", cyc, sb.pop_front());
        end
        if (bus_n.pps_strobe) begin
            check("inv_strobe_expected", 32'(sb_n.size() > 0), 32'd1);
            if (sb_n.size() > 0) check("inv_strobe_cycle", cyc, sb_n.pop_front());
        end
        if (bus.width_error) werr_count++;
        if (rst) begin
            clean_run   = 0;
            clean_run_n = 0;
        end else begin
            if (bus.pps_clean) clean_run++;
            else if (clean_run != 0) begin
                check("clean_width", clean_run, 32'd50);
                clean_run = 0;
            end
            if (bus_n.pps_clean) clean_run_n++;
            else if (clean_run_n != 0) begin
                check("inv_clean_width", clean_run_n, 32'd50);
                clean_run_n = 0;
            end
        end
    end

    initial begin
        rst = 1'b1;
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(10);

        // Clean pulses 10000 cycles apart.
        pulse(100, 1'b1);
        tick(9900);
        check("t1_width", bus.width_cycles, 32'd100);
        check("t1_pvalid_first", 32'(bus.period_valid), 32'd0);
        pulse(100, 1'b1);
        tick(20);
        check("t1_pvalid_second", 32'(bus.period_valid), 32'd1);
        check("t1_period_second", bus.period_cycles, 32'd10000);
        tick(9880);
        pulse(100, 1'b1);
        tick(20);
        check("t1_period_third", bus.period_cycles, 32'd10000);
        tick(5200);
        check("t1_no_werr", werr_count, 32'd0);
        check("t1_glitch", 32'(bus.glitch_count), 32'd0);
        check("t1_reject", 32'(bus.reject_count), 32'd0);

        // Glitch filter boundary: 3 cycles rejected, 4 accepted but narrow.
        pulse(3, 1'b0);
        tick(20);
        check("t2_glitch", 32'(bus.glitch_count), 32'd1);
        pulse(4, 1'b1);
        tick(20);
        check("t2_width", bus.width_cycles, 32'd4);
        check("t2_werr", werr_count, 32'd1);
        tick(5100);

        // Extra pulse inside holdoff.
        pulse(100, 1'b1);
        tick(1900);
        pulse(100, 1'b0);
        tick(7900);
        check("t3_reject", 32'(bus.reject_count), 32'd1);
        pulse(100, 1'b1);
        tick(20);
        check("t3_period", bus.period_cycles, 32'd10000);
        tick(5200);

        // Stuck-high input.
        sb.push_back(cyc + 6);
        raw = 1'b1;
        tick(3000);
        check("t4_stuck", 32'(bus.stuck_high), 32'd1);
        check("t4_width", bus.width_cycles, 32'd1000);
        check("t4_werr", werr_count, 32'd2);
        raw = 1'b0;
        tick(5);
        check("t4_stuck_clear", 32'(bus.stuck_high), 32'd0);
        tick(5100);

        // Pin high through reset release.
        rst = 1'b1;
        raw = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(50);
        raw = 1'b0;
        tick(10);
        pulse(100, 1'b1);
        tick(20);
        check("t5_sb_drained", sb.size(), 32'd0);
        check("t5_pvalid", 32'(bus.period_valid), 32'd0);
        tick(9880);

        // Reset while pps_clean is high.
        sb.push_back(cyc + 6);
        raw = 1'b1;
        tick(20);
        check("t6_clean_before", 32'(bus.pps_clean), 32'd1);
        check("t6_pvalid_before", 32'(bus.period_valid), 32'd1);
        check("t6_period_before", bus.period_cycles, 32'd10000);
        rst = 1'b1;
        tick(1);
        check_all_zero("t6_reset");
        rst = 1'b0;
        raw = 1'b0;
        tick(20);

        // Active-low source on the inverting instance.
        pulse_n(100);
        tick(9900);
        check("t6_inv_width", bus_n.width_cycles, 32'd100);
        check("t6_inv_pvalid_first", 32'(bus_n.period_valid), 32'd0);
        pulse_n(100);
        tick(20);
        check("t6_inv_pvalid", 32'(bus_n.period_valid), 32'd1);
        check("t6_inv_period", bus_n.period_cycles, 32'd10000);
        tick(40);

        check("end_sb_drained", sb.size(), 32'd0);
        check("end_inv_sb_drained", sb_n.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
